// File: rtl/riscv_pkg.sv
// Shared types and sizes for the register-file writeback path.
package riscv_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned CNT_W     = $clog2(REG_COUNT);

  // Writeback controller phases: clear x1..x31, then serve writebacks.
  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Writeback requester identity; also the round-robin history value.
  typedef enum logic {
    ReqAlu = 1'b0,
    ReqMem = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
module rr_arb2
  import riscv_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Combinational grant; bit 0 is the ALU, bit 1 is the load path.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == ReqMem) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller: clears x1..x31 after reset, then arbitrates
// ALU and load writebacks onto the single regfile write port.
module regfile_wb_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [ADDRESS_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [ADDRESS_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  output logic                     mem_ready,
  output logic                     we3,
  output logic [ADDRESS_WIDTH-1:0] ad3,
  output logic [DATA_WIDTH-1:0]    wd3,
  output logic                     init_done
);

  state_e                   r_state;
  state_e                   w_state_next;
  logic [CNT_W-1:0]         r_cnt;
  req_id_e                  r_last_grant;
  logic                     r_we3;
  logic [ADDRESS_WIDTH-1:0] r_ad3;
  logic [DATA_WIDTH-1:0]    r_wd3;
  logic                     r_init_done;

  logic                     w_run;
  logic                     w_last_clear;
  logic [1:0]               w_gnt;
  logic                     w_hs_alu;
  logic                     w_hs_mem;
  logic                     w_hs;
  logic [ADDRESS_WIDTH-1:0] w_hs_rd;
  logic [DATA_WIDTH-1:0]    w_hs_data;

  assign w_run        = (r_state == StRun);
  assign w_last_clear = (r_cnt == CNT_W'(REG_COUNT - 1));

  rr_arb2 u_arb (
    .req  ({mem_valid, alu_valid}),
    .last (r_last_grant),
    .gnt  (w_gnt)
  );

  // Readies are forced low during the clear phase and while reset is held.
  assign alu_ready = rst_n & w_run & alu_valid & w_gnt[0];
  assign mem_ready = rst_n & w_run & mem_valid & w_gnt[1];

  assign w_hs_alu  = alu_valid & alu_ready;
  assign w_hs_mem  = mem_valid & mem_ready;
  assign w_hs      = w_hs_alu | w_hs_mem;
  assign w_hs_rd   = w_hs_mem ? mem_rd : alu_rd;
  assign w_hs_data = w_hs_mem ? mem_data : alu_data;

  // Next state: leave INIT after the x31 clear; RUN is only left via reset.
  always_comb begin
    w_state_next = r_state;
    if (r_state == StInit && w_last_clear) begin
      w_state_next = StRun;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StInit;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Clear counter, round-robin history and registered write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= CNT_W'(1);
      r_last_grant <= ReqMem;
      r_we3        <= 1'b0;
      r_ad3        <= '0;
      r_wd3        <= '0;
      r_init_done  <= 1'b0;
    end else if (!w_run) begin
      r_we3 <= 1'b1;
      r_ad3 <= ADDRESS_WIDTH'(r_cnt);
      r_wd3 <= '0;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last_clear) begin
        r_init_done <= 1'b1;
      end
    end else if (w_hs) begin
      r_last_grant <= w_hs_mem ? ReqMem : ReqAlu;
      // Writes to x0 are accepted but dropped; address/data keep their old values.
      if (w_hs_rd != '0) begin
        r_we3 <= 1'b1;
        r_ad3 <= w_hs_rd;
        r_wd3 <= w_hs_data;
      end else begin
        r_we3 <= 1'b0;
      end
    end else begin
      r_we3 <= 1'b0;
    end
  end

  assign we3       = r_we3;
  assign ad3       = r_ad3;
  assign wd3       = r_wd3;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl against a behavioural writeback model.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_rd, mem_rd;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready;
  logic        we3;
  logic [4:0]  ad3;
  logic [31:0] wd3;
  logic        init_done;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model: phase flag, clear index, who won the last tie, expected port.
  bit          m_run;
  int          m_cnt;
  int          m_last;          // 0 = ALU, 1 = MEM
  logic        m_we;
  logic [4:0]  m_ad;
  logic [31:0] m_wd;
  logic        m_done;
  logic [31:0] m_regs [32];
  logic [31:0] s_regs [32];     // regfile image built from DUT writes

  regfile_wb_ctrl #(
    .ADDRESS_WIDTH (5),
    .DATA_WIDTH    (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .we3       (we3),
    .ad3       (ad3),
    .wd3       (wd3),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check readies, model the edge, check the write port.
  task automatic cycle(input logic rstn, input logic av, input logic [4:0] ar,
                       input logic [31:0] ad, input logic mv, input logic [4:0] mr,
                       input logic [31:0] md);
    bit ga, gm;
    @(negedge clk);
    rst_n = rstn; alu_valid = av; alu_rd = ar; alu_data = ad;
    mem_valid = mv; mem_rd = mr; mem_data = md;
    #1;
    ga = 0; gm = 0;
    if (rstn && m_run) begin
      if (av && mv) begin
        if (m_last == 1) ga = 1; else gm = 1;
      end else begin
        ga = av; gm = mv;
      end
    end
    chk("alu_ready", alu_ready, ga);
    chk("mem_ready", mem_ready, gm);
    @(posedge clk);
    if (!rstn) begin
      m_run = 0; m_cnt = 1; m_last = 1;
      m_we = 0; m_ad = 0; m_wd = 0; m_done = 0;
    end else if (!m_run) begin
      m_we = 1; m_ad = m_cnt[4:0]; m_wd = 0;
      if (m_cnt == 31) begin
        m_run = 1; m_done = 1;
      end
      m_cnt = m_cnt + 1;
    end else if (ga || gm) begin
      m_last = gm ? 1 : 0;
      if ((gm ? mr : ar) != 0) begin
        m_we = 1; m_ad = gm ? mr : ar; m_wd = gm ? md : ad;
      end else begin
        m_we = 0;
      end
    end else begin
      m_we = 0;
    end
    if (m_we) m_regs[m_ad] = m_wd;
    #1;
    chk("we3", we3, m_we);
    chk("ad3", ad3, m_ad);
    chk("wd3", wd3, m_wd);
    chk("init_done", init_done, m_done);
    if (we3 === 1'b1) s_regs[ad3] = wd3;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      s_regs[i] = 32'h0;
    end
    m_run = 0; m_cnt = 1; m_last = 1; m_we = 0; m_ad = 0; m_wd = 0; m_done = 0;
    rst_n = 0; alu_valid = 0; mem_valid = 0;
    alu_rd = 0; mem_rd = 0; alu_data = 0; mem_data = 0;

    // Reset held with requests pending: readies stay low, outputs zero.
    cycle(0, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2);
    cycle(0, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2);

    // Partial clear up to cnt=10, then a one-edge reset restarts the sequence.
    idle(9);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // Full clear with an ALU request pending throughout; taken on the first RUN cycle.
    for (int i = 0; i < 31; i++) cycle(1, 1, 5'd7, 32'hCAFE_0007, 0, 0, 0);
    for (int i = 1; i < 32; i++) chk($sformatf("clear_x%0d", i), s_regs[i], 32'h0);
    cycle(1, 1, 5'd7, 32'hCAFE_0007, 0, 0, 0);
    idle(1);

    // Single ALU writeback.
    cycle(1, 1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0);
    idle(1);

    // Load to x0 is accepted but dropped; the following tie goes to the ALU.
    cycle(1, 0, 0, 0, 1, 5'd0, 32'h1234);
    cycle(1, 1, 5'd9, 32'h9999_0000, 1, 5'd10, 32'hAAAA_0000);
    idle(1);

    // Fresh reset, then continuous ties alternate ALU, MEM, ALU, MEM.
    cycle(0, 0, 0, 0, 0, 0, 0);
    idle(31);
    for (int i = 0; i < 4; i++) cycle(1, 1, 5'd1, 32'h100 + i, 1, 5'd2, 32'h200 + i);
    idle(1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom);
    end
    idle(2);

    for (int i = 0; i < 32; i++) chk($sformatf("regfile_x%0d", i), s_regs[i], m_regs[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
